// File: rtl/lif_mon_pkg.sv
// lif_mon_pkg: shared widths, saturation limits and FSM states for the spike monitor
package lif_mon_pkg;
  localparam int WINDOW_LEN_DEF = 256;
  localparam int CNT_W_DEF = 8;
  localparam int ISI_W_DEF = 12;
  localparam int CNT_MAX = 2**CNT_W_DEF - 1;
  localparam int ISI_MAX = 2**ISI_W_DEF - 1;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUNNING = 2'd2} state_e;
endpackage

// File: rtl/spike_window_monitor_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at its all-ones maximum
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);
  logic [W-1:0] q_q, q_d;
  assign q = q_q;
  assign sat = &q_q;
  // clear wins over increment; increment is ignored once at maximum
  always_comb q_d = clr ? '0 : (inc && !sat) ? q_q + 1'b1 : q_q;
  // count register
  always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
endmodule

// File: rtl/spike_window_monitor.sv
// spike_window_monitor: windowed spike count and inter-spike interval readout
module spike_window_monitor
  import lif_mon_pkg::*;
#(
  parameter int WINDOW_LEN = WINDOW_LEN_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ISI_W = ISI_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_sat,
  output logic             cnt_valid,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_sat,
  output logic             isi_valid,
  output logic             busy
);
  localparam int WIN_W = $clog2(WINDOW_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);
  state_e state_q, state_d;
  logic spike_d_q, spk, run, term, first, isi_fire;
  logic [WIN_W-1:0] win_q, win_d;
  logic have_prev_q, have_prev_d, sat_q, sat_d;
  logic [CNT_W-1:0] acc, cnt_out_q, cnt_out_d;
  logic acc_full, acc_clr, acc_inc;
  logic [ISI_W-1:0] tmr, isi_out_q, isi_out_d;
  logic tmr_full, tmr_clr, tmr_inc;
  logic cnt_sat_q, cnt_sat_d, cnt_valid_q, cnt_valid_d;
  logic isi_sat_q, isi_sat_d, isi_valid_q, isi_valid_d, busy_q, busy_d;
  assign spk = spike_in & ~spike_d_q;
  assign run = en && state_q == RUNNING;
  assign term = run && win_q == WIN_LAST;
  assign first = en && state_q == ARMED && spk;
  assign isi_fire = run && spk && have_prev_q;
  assign acc_clr = !en || term;
  assign acc_inc = en && state_q != IDLE && spk;
  assign tmr_clr = !en || spk;
  assign tmr_inc = run;
  sat_counter #(.W(CNT_W)) u_acc (
    .clk(clk), .rst(rst), .clr(acc_clr), .inc(acc_inc), .q(acc), .sat(acc_full)
  );
  sat_counter #(.W(ISI_W)) u_isi_tmr (
    .clk(clk), .rst(rst), .clr(tmr_clr), .inc(tmr_inc), .q(tmr), .sat(tmr_full)
  );
  // state transitions; dropping en always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (!en) state_d = IDLE;
    else if (state_q == IDLE) state_d = ARMED;
    else if (first) state_d = RUNNING;
  end
  // window position, sticky overflow, result registers and strobes
  always_comb begin
    win_d = (!en || term) ? '0 : first ? WIN_W'(1) : run ? win_q + 1'b1 : win_q;
    have_prev_d = !en ? 1'b0 : acc_inc ? 1'b1 : have_prev_q;
    sat_d = (!en || term) ? 1'b0 : (run && spk && acc_full) ? 1'b1 : sat_q;
    cnt_out_d = term ? (acc_full ? '1 : acc + CNT_W'(spk)) : cnt_out_q;
    cnt_sat_d = term ? (sat_q | (spk & acc_full)) : cnt_sat_q;
    cnt_valid_d = term;
    isi_out_d = isi_fire ? (tmr_full ? '1 : tmr + 1'b1) : isi_out_q;
    isi_sat_d = isi_fire ? tmr_full : isi_sat_q;
    isi_valid_d = isi_fire;
    busy_d = state_d != IDLE;
  end
  // all state registers; reset overrides en and spike_in
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      spike_d_q <= 1'b0;
      win_q <= '0;
      have_prev_q <= 1'b0;
      sat_q <= 1'b0;
      cnt_out_q <= '0;
      cnt_sat_q <= 1'b0;
      cnt_valid_q <= 1'b0;
      isi_out_q <= '0;
      isi_sat_q <= 1'b0;
      isi_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      spike_d_q <= spike_in;
      win_q <= win_d;
      have_prev_q <= have_prev_d;
      sat_q <= sat_d;
      cnt_out_q <= cnt_out_d;
      cnt_sat_q <= cnt_sat_d;
      cnt_valid_q <= cnt_valid_d;
      isi_out_q <= isi_out_d;
      isi_sat_q <= isi_sat_d;
      isi_valid_q <= isi_valid_d;
      busy_q <= busy_d;
    end
  end
  assign cnt_out = cnt_out_q;
  assign cnt_sat = cnt_sat_q;
  assign cnt_valid = cnt_valid_q;
  assign isi_out = isi_out_q;
  assign isi_sat = isi_sat_q;
  assign isi_valid = isi_valid_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_spike_window_monitor.sv
// tb_spike_window_monitor: directed scenarios for windowed spike count and ISI readout
module tb_spike_window_monitor;
  localparam int WL = 16;
  localparam int CW = 3;
  localparam int IW = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic spike_in = 1'b0;
  logic [CW-1:0] cnt_out;
  logic cnt_sat, cnt_valid;
  logic [IW-1:0] isi_out;
  logic isi_sat, isi_valid, busy;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  spike_window_monitor #(.WINDOW_LEN(WL), .CNT_W(CW), .ISI_W(IW)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .cnt_out(cnt_out), .cnt_sat(cnt_sat), .cnt_valid(cnt_valid),
    .isi_out(isi_out), .isi_sat(isi_sat), .isi_valid(isi_valid), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic restart();
    rst = 1'b1; en = 1'b0; spike_in = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1;
    tick();
  endtask
  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      spike_in = i[0];
      tick();
      vecs++;
      if ({cnt_out, cnt_sat, cnt_valid, isi_out, isi_sat, isi_valid, busy} !== '0) begin
        errs++;
        $display("FAIL reset_outputs i=%0d got %b exp 0", i, {cnt_out, cnt_sat, cnt_valid, isi_out, isi_sat, isi_valid, busy});
      end
    end
    rst = 1'b0; en = 1'b0; spike_in = 1'b0;
    tick();
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL busy_idle got %b exp 0", busy); end
    en = 1'b1;
    tick();
    vecs++;
    if (busy !== 1'b1) begin errs++; $display("FAIL busy_armed got %b exp 1", busy); end
  endtask
  task automatic test_rate();
    restart();
    for (int k = 0; k < 20; k++) begin
      spike_in = (k % 4 == 0);
      tick();
      vecs++;
      if (cnt_valid !== (k == 15)) begin errs++; $display("FAIL rate_cnt_valid k=%0d got %b", k, cnt_valid); end
      vecs++;
      if (isi_valid !== (k % 4 == 0 && k > 0)) begin errs++; $display("FAIL rate_isi_valid k=%0d got %b", k, isi_valid); end
      if (k == 15) begin
        vecs++;
        if (cnt_out !== 3'd4 || cnt_sat !== 1'b0) begin errs++; $display("FAIL rate_cnt got %0d/%b exp 4/0", cnt_out, cnt_sat); end
      end
      if (k % 4 == 0 && k > 0) begin
        vecs++;
        if (isi_out !== 4'd4 || isi_sat !== 1'b0) begin errs++; $display("FAIL rate_isi k=%0d got %0d/%b exp 4/0", k, isi_out, isi_sat); end
      end
    end
  endtask
  task automatic test_hold_and_terminal();
    restart();
    for (int k = 0; k < 32; k++) begin
      spike_in = (k < 10) || (k == 15);
      tick();
      vecs++;
      if (cnt_valid !== (k == 15 || k == 31)) begin errs++; $display("FAIL hold_cnt_valid k=%0d got %b", k, cnt_valid); end
      vecs++;
      if (isi_valid !== (k == 15)) begin errs++; $display("FAIL hold_isi_valid k=%0d got %b", k, isi_valid); end
      if (k == 15) begin
        vecs++;
        if (cnt_out !== 3'd2) begin errs++; $display("FAIL hold_cnt_w1 got %0d exp 2", cnt_out); end
        vecs++;
        if (isi_out !== 4'd15 || isi_sat !== 1'b0) begin errs++; $display("FAIL hold_isi got %0d/%b exp 15/0", isi_out, isi_sat); end
      end
      if (k == 31) begin
        vecs++;
        if (cnt_out !== 3'd0) begin errs++; $display("FAIL terminal_next_window got %0d exp 0", cnt_out); end
      end
    end
  endtask
  task automatic test_saturation();
    restart();
    for (int k = 0; k < 32; k++) begin
      spike_in = (k < 16 && k % 2 == 0) || k == 20 || k == 24;
      tick();
      if (k == 2) begin
        vecs++;
        if (isi_valid !== 1'b1 || isi_out !== 4'd2) begin errs++; $display("FAIL min_isi got %b/%0d exp 1/2", isi_valid, isi_out); end
      end
      if (k == 15) begin
        vecs++;
        if (cnt_valid !== 1'b1 || cnt_out !== 3'd7 || cnt_sat !== 1'b1) begin errs++; $display("FAIL sat_window got %b/%0d/%b exp 1/7/1", cnt_valid, cnt_out, cnt_sat); end
      end
      if (k == 20) begin
        vecs++;
        if (isi_out !== 4'd6) begin errs++; $display("FAIL sat_isi_gap got %0d exp 6", isi_out); end
      end
      if (k == 31) begin
        vecs++;
        if (cnt_valid !== 1'b1 || cnt_out !== 3'd2 || cnt_sat !== 1'b0) begin errs++; $display("FAIL post_sat_window got %b/%0d/%b exp 1/2/0", cnt_valid, cnt_out, cnt_sat); end
      end
    end
  endtask
  task automatic test_isi_sat();
    restart();
    for (int k = 0; k < 25; k++) begin
      spike_in = (k == 0 || k == 20 || k == 23);
      tick();
      vecs++;
      if (isi_valid !== (k == 20 || k == 23)) begin errs++; $display("FAIL isi_valid k=%0d got %b", k, isi_valid); end
      if (k == 20) begin
        vecs++;
        if (isi_out !== 4'd15 || isi_sat !== 1'b1) begin errs++; $display("FAIL isi_sat got %0d/%b exp 15/1", isi_out, isi_sat); end
      end
      if (k == 23) begin
        vecs++;
        if (isi_out !== 4'd3 || isi_sat !== 1'b0) begin errs++; $display("FAIL isi_after_sat got %0d/%b exp 3/0", isi_out, isi_sat); end
      end
    end
  endtask
  task automatic test_en_drop_and_rst();
    restart();
    for (int k = 0; k < 42; k++) begin
      spike_in = (k == 0 || k == 4 || k == 18 || k == 36 || k == 40);
      en = !(k == 20 || k == 21);
      tick();
      vecs++;
      if (cnt_valid !== (k == 15)) begin errs++; $display("FAIL drop_cnt_valid k=%0d got %b", k, cnt_valid); end
      vecs++;
      if (isi_valid !== (k == 4 || k == 18 || k == 40)) begin errs++; $display("FAIL drop_isi_valid k=%0d got %b", k, isi_valid); end
      vecs++;
      if (busy !== !(k == 20 || k == 21)) begin errs++; $display("FAIL drop_busy k=%0d got %b", k, busy); end
      if (k == 35) begin
        vecs++;
        if (cnt_out !== 3'd2) begin errs++; $display("FAIL drop_cnt_hold got %0d exp 2", cnt_out); end
      end
      if (k == 40) begin
        vecs++;
        if (isi_out !== 4'd4) begin errs++; $display("FAIL rearm_isi got %0d exp 4", isi_out); end
      end
    end
    spike_in = 1'b1;
    rst = 1'b1;
    tick();
    vecs++;
    if ({cnt_out, cnt_sat, cnt_valid, isi_out, isi_sat, isi_valid, busy} !== '0) begin
      errs++;
      $display("FAIL midwindow_rst got %b exp 0", {cnt_out, cnt_sat, cnt_valid, isi_out, isi_sat, isi_valid, busy});
    end
    rst = 1'b0;
    spike_in = 1'b0;
  endtask
  initial begin
    test_reset();
    test_rate();
    test_hold_and_terminal();
    test_saturation();
    test_isi_sat();
    test_en_drop_and_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
